fp32_div_round_pack: RTL and testbench

- Downstream back-end of the FP32 divide path. Consumes the raw quotient from the divider core: sign, unnormalised biased exponent, and a 48-bit mantissa quotient.
- Normalises, rounds round-to-nearest-even, applies special-case and range handling, and packs the IEEE-754 single result with exception flags.
- Two-stage elastic pipeline with valid/ready on both sides, so it can sit between the combinational divider and the ALU result mux.

---
 rtl/fp32_pkg.sv | 48 ++++
 rtl/fp32_rne_round.sv | 39 +++
 rtl/fp32_div_round_pack.sv | 147 ++++++++++++++
 tb/tb_fp32_div_round_pack.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions for the divide/multiply back-ends.
// Holds the field widths, the class-bit and flag-bit positions, the special
// encodings, the stage-1 payload struct and a small field-packing helper.
package fp32_pkg;

  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int BIAS     = 127;
  // Exponents are carried wider than EXP_W, so that underflow and overflow
  // survive the -1 of normalisation and the +1 of the rounding carry.
  localparam int E_INT_W  = 11;
  localparam int EXP_MAX  = 2 * BIAS + 1;

  // Positions in the class vector {A_nan, B_nan, A_inf, B_inf, A_zero, B_zero}.
  localparam int CLS_A_NAN  = 5;
  localparam int CLS_B_NAN  = 4;
  localparam int CLS_A_INF  = 3;
  localparam int CLS_B_INF  = 2;
  localparam int CLS_A_ZERO = 1;
  localparam int CLS_B_ZERO = 0;

  // Positions in the flag vector {invalid, div_by_zero, overflow, underflow, inexact}.
  localparam int FLG_INVALID   = 4;
  localparam int FLG_DIVZERO   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] INF_MAG = 31'h7F80_0000;

  // Normalised operand held between the two pipeline stages.
  typedef struct packed {
    logic               sign;
    logic [5:0]         cls;
    logic [E_INT_W-1:0] e;
    logic [MAN_W:0]     mant;
    logic               g;
    logic               s;
  } s1_t;

  function automatic logic [31:0] fp_pack(input logic sign,
                                          input logic [EXP_W-1:0] e,
                                          input logic [MAN_W-1:0] frac);
    return {sign, e, frac};
  endfunction

endpackage

// File: rtl/fp32_rne_round.sv
// Round-to-nearest-even of a normalised 24-bit significand.
// Ports:
//   mant     - significand with hidden bit (bit 23)
//   g, s     - guard bit and sticky OR of everything below it
//   e        - biased exponent, two's complement, E_INT_W bits
//   rnd_mant - rounded significand (hidden bit still present)
//   rnd_e    - exponent after a possible rounding carry
//   inexact  - any nonzero bits were discarded
module fp32_rne_round
  import fp32_pkg::*;
(
  input  logic [MAN_W:0]       mant,
  input  logic                 g,
  input  logic                 s,
  input  logic [E_INT_W-1:0]   e,
  output logic [MAN_W:0]       rnd_mant,
  output logic [E_INT_W-1:0]   rnd_e,
  output logic                 inexact
);

  logic               rup_s;
  logic [MAN_W+1:0]   sum_s;

  // Round up above half, or at exactly half when the kept LSB is odd.
  always_comb begin
    rup_s = g & (s | mant[0]);
    sum_s = {1'b0, mant} + {{(MAN_W + 1){1'b0}}, rup_s};
    if (sum_s[MAN_W+1]) begin
      // 1.111..1 rounded up to 10.000..0: renormalise by one place.
      rnd_mant = {1'b1, {MAN_W{1'b0}}};
      rnd_e    = e + 11'd1;
    end else begin
      rnd_mant = sum_s[MAN_W:0];
      rnd_e    = e;
    end
    inexact = g | s;
  end

endmodule

// File: rtl/fp32_div_round_pack.sv
// FP32 divide back-end: normalise, round (RNE), range/special handling and
// IEEE-754 single packing, as a two-stage valid/ready pipeline.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - upstream handshake (in_ready depends on out_ready)
//   in_sign, in_exp, in_q - raw quotient: sign, biased exponent, Q1.47 mantissa
//   in_cls                - operand classes {A_nan,B_nan,A_inf,B_inf,A_zero,B_zero}
//   out_valid / out_ready - downstream handshake
//   DivProd               - packed FP32 result (registered)
//   out_flags             - {invalid, div_by_zero, overflow, underflow, inexact}
module fp32_div_round_pack
  import fp32_pkg::*;
#(
  parameter int          FLUSH_SUBNORMAL = 1,
  parameter logic [31:0] NAN_PATTERN     = QNAN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [9:0]  in_exp,
  input  logic [47:0] in_q,
  input  logic [5:0]  in_cls,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] DivProd,
  output logic [4:0]  out_flags
);

  logic               s1_valid_r;
  logic               s2_valid_r;
  s1_t                s1_r;
  s1_t                s1_nxt_s;
  logic               s2_adv_s;
  logic               s1_load_s;
  logic               s2_load_s;
  logic [MAN_W:0]     rnd_mant_s;
  logic [E_INT_W-1:0] rnd_e_s;
  logic               rnd_inexact_s;
  logic [31:0]        res_s;
  logic [4:0]         flags_s;
  logic               is_nan_s;

  // Stage 2 frees up when empty or draining; stage 1 then frees up behind it.
  assign s2_adv_s  = !s2_valid_r || out_ready;
  assign in_ready  = !s1_valid_r || s2_adv_s;
  assign s1_load_s = in_valid && in_ready;
  assign s2_load_s = s1_valid_r && s2_adv_s;
  assign out_valid = s2_valid_r;

  // Normalise the Q1.47 quotient so the kept 24 bits start with a 1.
  always_comb begin
    s1_nxt_s.sign = in_sign;
    s1_nxt_s.cls  = in_cls;
    if (in_q[47]) begin
      s1_nxt_s.mant = in_q[47:24];
      s1_nxt_s.g    = in_q[23];
      s1_nxt_s.s    = |in_q[22:0];
      s1_nxt_s.e    = {in_exp[9], in_exp};
    end else begin
      s1_nxt_s.mant = in_q[46:23];
      s1_nxt_s.g    = in_q[22];
      s1_nxt_s.s    = |in_q[21:0];
      s1_nxt_s.e    = {in_exp[9], in_exp} - 11'd1;
    end
  end

  // Pipeline occupancy: each stage refills whenever its consumer moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_r <= in_valid;
      end
      if (s2_adv_s) begin
        s2_valid_r <= s1_valid_r;
      end
    end
  end

  // Stage 1 payload register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r <= '0;
    end else if (s1_load_s) begin
      s1_r <= s1_nxt_s;
    end
  end

  fp32_rne_round u_round (
    .mant     (s1_r.mant),
    .g        (s1_r.g),
    .s        (s1_r.s),
    .e        (s1_r.e),
    .rnd_mant (rnd_mant_s),
    .rnd_e    (rnd_e_s),
    .inexact  (rnd_inexact_s)
  );

  assign is_nan_s = s1_r.cls[CLS_A_NAN] | s1_r.cls[CLS_B_NAN]
                  | (s1_r.cls[CLS_A_ZERO] & s1_r.cls[CLS_B_ZERO])
                  | (s1_r.cls[CLS_A_INF]  & s1_r.cls[CLS_B_INF]);

  // Special cases first (in priority order), then range, then a normal pack.
  always_comb begin
    res_s   = 32'h0000_0000;
    flags_s = 5'b00000;
    if (is_nan_s) begin
      res_s                = NAN_PATTERN;
      flags_s[FLG_INVALID] = 1'b1;
    end else if (s1_r.cls[CLS_B_ZERO] && !s1_r.cls[CLS_A_INF] && !s1_r.cls[CLS_A_ZERO]) begin
      res_s                = {s1_r.sign, INF_MAG};
      flags_s[FLG_DIVZERO] = 1'b1;
    end else if (s1_r.cls[CLS_A_INF]) begin
      res_s = {s1_r.sign, INF_MAG};
    end else if (s1_r.cls[CLS_A_ZERO] || s1_r.cls[CLS_B_INF]) begin
      res_s = {s1_r.sign, 31'h0000_0000};
    end else if (int'($signed(rnd_e_s)) >= EXP_MAX) begin
      res_s                 = {s1_r.sign, INF_MAG};
      flags_s[FLG_OVERFLOW] = 1'b1;
      flags_s[FLG_INEXACT]  = 1'b1;
    end else if ((FLUSH_SUBNORMAL != 0) && (int'($signed(rnd_e_s)) <= 32'sd0)) begin
      res_s                  = {s1_r.sign, 31'h0000_0000};
      flags_s[FLG_UNDERFLOW] = 1'b1;
      // Flushed to zero: inexact whenever the quotient itself was nonzero.
      flags_s[FLG_INEXACT]   = (|rnd_mant_s) | rnd_inexact_s;
    end else begin
      res_s                = fp_pack(s1_r.sign, rnd_e_s[EXP_W-1:0], rnd_mant_s[MAN_W-1:0]);
      flags_s[FLG_INEXACT] = rnd_inexact_s;
    end
  end

  // Stage 2 result register drives the outputs; it moves only on a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      DivProd   <= 32'h0000_0000;
      out_flags <= 5'b00000;
    end else if (s2_load_s) begin
      DivProd   <= res_s;
      out_flags <= flags_s;
    end
  end

endmodule

// File: tb/tb_fp32_div_round_pack.sv
// Self-checking bench for fp32_div_round_pack: directed test-plan cases,
// backpressure, asynchronous reset mid-flight and a randomized stream
// scored against an arithmetic reference model.
module tb_fp32_div_round_pack;

  typedef struct packed {
    logic        sgn;
    logic [9:0]  ex;
    logic [47:0] q;
    logic [5:0]  cls;
  } op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [9:0]  in_exp;
  logic [47:0] in_q;
  logic [5:0]  in_cls;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] DivProd;
  logic [4:0]  out_flags;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int n_out = 0;
  logic last_acc;
  logic [36:0] exp_q[$];

  fp32_div_round_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_q(in_q), .in_cls(in_cls),
    .out_valid(out_valid), .out_ready(out_ready),
    .DivProd(DivProd), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  // Reference: {flags, result} derived from the value-level rules.
  function automatic logic [36:0] model(input op_t o);
    int          e;
    int          sh;
    longint      keep;
    longint      rem;
    longint      half;
    logic [5:0]  c;
    c = o.cls;
    if (c[5] || c[4] || (c[1] && c[0]) || (c[3] && c[2])) return {5'b10000, 32'h7FC0_0000};
    if (c[0] && !c[3] && !c[1]) return {5'b01000, o.sgn, 31'h7F80_0000};
    if (c[3]) return {5'b00000, o.sgn, 31'h7F80_0000};
    if (c[1] || c[2]) return {5'b00000, o.sgn, 31'h0};
    sh   = o.q[47] ? 24 : 23;
    e    = int'($signed(o.ex)) - (o.q[47] ? 0 : 1);
    keep = longint'(o.q >> sh);
    rem  = longint'(o.q) - (keep << sh);
    half = 64'sd1 <<< (sh - 1);
    if (rem > half || (rem == half && keep[0])) keep = keep + 1;
    if (keep == (64'sd1 <<< 24)) begin
      keep = keep >>> 1;
      e    = e + 1;
    end
    if (e >= 255) return {5'b00101, o.sgn, 31'h7F80_0000};
    if (e <= 0) return {3'b000, 1'b1, (o.q != 48'h0), o.sgn, 31'h0};
    return {4'b0000, (rem != 0), o.sgn, 8'(e), keep[22:0]};
  endfunction

  task automatic chk(input string tag, input logic [36:0] obs, input logic [36:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive(input op_t o);
    in_sign = o.sgn;
    in_exp  = o.ex;
    in_q    = o.q;
    in_cls  = o.cls;
  endtask

  // One clock: sample handshakes mid-cycle, score emissions, advance to next negedge.
  task automatic step();
    op_t cur;
    #1;
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      n_out++;
      n_cmp++;
      assert (exp_q.size() > 0) else begin
        n_bad++;
        $error("FAIL stream_extra: observed result %h expected none", DivProd);
      end
      if (exp_q.size() > 0) chk("stream", {out_flags, DivProd}, exp_q.pop_front());
    end
    if (last_acc) begin
      cur = '{in_sign, in_exp, in_q, in_cls};
      exp_q.push_back(model(cur));
      n_acc++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single op through an idle pipeline: checks latency and the exact result.
  task automatic directed(input string tag, input op_t o, input logic [36:0] want);
    int na;
    na = n_acc;
    drive(o);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_acc"}, 37'(n_acc - na), 37'd1);
    chk({tag, "_lat1"}, 37'(out_valid), 37'd0);
    step();
    chk({tag, "_lat2"}, 37'(out_valid), 37'd1);
    chk(tag, {out_flags, DivProd}, want);
    step();
  endtask

  function automatic op_t rand_op();
    op_t        o;
    logic [63:0] r;
    r     = {$urandom, $urandom};
    o.sgn = r[63];
    o.q   = r[0] ? {1'b1, r[47:1]} : {2'b01, r[47:2]};
    if (r[62:60] == 3'd0) o.q[21:0] = 22'h0;
    o.ex  = 10'(int'($urandom_range(0, 300)) - 20);
    o.cls = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
    return o;
  endfunction

  initial begin
    op_t        bp_ops[4];
    op_t        cur;
    logic [31:0] hold;
    int         idx;
    int         base_out;
    int         base_acc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive('{1'b0, 10'd0, 48'h0, 6'd0});
    #1;
    chk("rst_out_valid", 37'(out_valid), 37'd0);
    chk("rst_in_ready", 37'(in_ready), 37'd1);
    chk("rst_data", {out_flags, DivProd}, 37'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    directed("div_6_2",   '{1'b0, 10'd128, 48'hC000_0000_0000, 6'd0},  {5'b00000, 32'h4040_0000});
    directed("div_1_3",   '{1'b0, 10'd126, 48'h5555_5555_5555, 6'd0},  {5'b00001, 32'h3EAA_AAAB});
    directed("ovf",       '{1'b0, 10'd260, 48'h8000_0000_0000, 6'd0},  {5'b00101, 32'h7F80_0000});
    directed("unf",       '{1'b0, 10'h3FB, 48'h8000_0000_0000, 6'd0},  {5'b00011, 32'h0000_0000});
    directed("zero_zero", '{1'b0, 10'd127, 48'h8000_0000_0000, 6'b000011}, {5'b10000, 32'h7FC0_0000});
    directed("div_zero",  '{1'b1, 10'd127, 48'h8000_0000_0000, 6'b000001}, {5'b01000, 32'hFF80_0000});
    directed("inf_zero",  '{1'b1, 10'd127, 48'h8000_0000_0000, 6'b001001}, {5'b00000, 32'hFF80_0000});
    directed("b_inf",     '{1'b1, 10'd127, 48'h8000_0000_0000, 6'b000100}, {5'b00000, 32'h8000_0000});
    directed("rnd_carry", '{1'b0, 10'd127, 48'hFFFF_FF80_0000, 6'd0},  {5'b00001, 32'h4000_0000});
    directed("tie_even",  '{1'b0, 10'd127, 48'h8000_0080_0000, 6'd0},  {5'b00001, 32'h3F80_0000});
    directed("rnd_ovf",   '{1'b0, 10'd254, 48'hFFFF_FF80_0000, 6'd0},  {5'b00101, 32'h7F80_0000});
    directed("min_norm",  '{1'b0, 10'd2,   48'h4000_0000_0000, 6'd0},  {5'b00000, 32'h0080_0000});
    directed("e_zero",    '{1'b1, 10'd1,   48'h4000_0000_0000, 6'd0},  {5'b00011, 32'h8000_0000});

    // Backpressure: four ops against a stalled sink.
    for (int i = 0; i < 4; i++) bp_ops[i] = rand_op();
    base_acc  = n_acc;
    base_out  = n_out;
    idx       = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 7; c++) begin
      drive(bp_ops[idx]);
      in_valid = 1'b1;
      step();
      if (last_acc) idx++;
      if (c == 3) begin
        chk("bp_accepts", 37'(n_acc - base_acc), 37'd2);
        chk("bp_in_ready", 37'(in_ready), 37'd0);
        hold = DivProd;
      end
    end
    chk("bp_hold", 37'(DivProd), 37'(hold));
    out_ready = 1'b1;
    for (int c = 0; c < 40 && (idx < 4 || exp_q.size() > 0); c++) begin
      if (idx < 4) begin
        drive(bp_ops[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("bp_count", 37'(n_out - base_out), 37'd4);

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(rand_op());
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 37'(out_valid), 37'd0);
    chk("arst_in_ready", 37'(in_ready), 37'd1);
    chk("arst_data", {out_flags, DivProd}, 37'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    base_out  = n_out;
    repeat (6) step();
    chk("arst_no_stale", 37'(n_out - base_out), 37'd0);
    chk("arst_ready_after", 37'(in_ready), 37'd1);

    // Randomized stream with random valid/ready gaps.
    idx      = 0;
    base_out = n_out;
    cur      = rand_op();
    for (int c = 0; c < 3000 && (idx < 300 || exp_q.size() > 0); c++) begin
      drive(cur);
      in_valid  = (idx < 300) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
      if (last_acc) begin
        idx++;
        cur = rand_op();
      end
    end
    in_valid = 1'b0;
    chk("rand_count", 37'(n_out - base_out), 37'd300);
    chk("rand_drained", 37'(exp_q.size()), 37'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
